multiplier_arbiter: RTL and testbench

- Shares one shift-add multiplier datapath between two requesters (port 0, port 1) using round-robin arbitration.
- Replaces the unrolled per-bit state graph with a counter-sequenced controller that skips add cycles for zero multiplier bits.
- Each port gets a one-cycle grant, a one-cycle done pulse and a held result register.
- Sits between client blocks and the shared multiplier resource.

---
 rtl/multiplier_arbiter_pkg.sv | 14 +
 rtl/multiplier_arbiter_shift_add_datapath.sv | 51 +++++
 rtl/multiplier_arbiter.sv | 179 +++++++++++++++++
 tb/tb_multiplier_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_arbiter_pkg.sv
// Shared definitions for the two-port shift-add multiplier arbiter:
// controller state encodings and default operand/counter widths.
package multiplier_arbiter_pkg;

    localparam int L_WORD_DEFAULT = 4;
    localparam int L_CNT_DEFAULT  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multiplier_arbiter_shift_add_datapath.sv
// Shared shift-add datapath: holds multiplicand, multiplier and accumulator;
// the controller issues exactly one of load/add/shift per cycle.
module shift_add_datapath
    import multiplier_arbiter_pkg::*;
#(
    parameter int L_word = L_WORD_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                add,
    input  logic                shift,
    input  logic [L_word-1:0]   word1,
    input  logic [L_word-1:0]   word2,
    output logic                m0,
    output logic [2*L_word-1:0] acc
);

    logic [2*L_word-1:0] multiplicand_r;
    logic [L_word-1:0]   multiplier_r;
    logic [2*L_word-1:0] acc_r;

    // Operand and accumulator registers; load takes priority over add and shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            multiplicand_r <= {(2*L_word){1'b0}};
            multiplier_r   <= {L_word{1'b0}};
            acc_r          <= {(2*L_word){1'b0}};
        end else if (load) begin
            multiplicand_r <= {{L_word{1'b0}}, word1};
            multiplier_r   <= word2;
            acc_r          <= {(2*L_word){1'b0}};
        end else if (add) begin
            multiplicand_r <= multiplicand_r;
            multiplier_r   <= multiplier_r;
            acc_r          <= acc_r + multiplicand_r;
        end else if (shift) begin
            multiplicand_r <= multiplicand_r << 1;
            multiplier_r   <= multiplier_r >> 1;
            acc_r          <= acc_r;
        end else begin
            multiplicand_r <= multiplicand_r;
            multiplier_r   <= multiplier_r;
            acc_r          <= acc_r;
        end
    end

    assign m0  = multiplier_r[0];
    assign acc = acc_r;

endmodule

// File: rtl/multiplier_arbiter.sv
// Two-port round-robin arbiter in front of one shared shift-add multiplier;
// counter-sequenced controller that skips the add cycle for zero multiplier bits.
module multiplier_arbiter
    import multiplier_arbiter_pkg::*;
#(
    parameter int L_word = L_WORD_DEFAULT,
    parameter int L_cnt  = L_CNT_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_0,
    input  logic [L_word-1:0]   word1_0,
    input  logic [L_word-1:0]   word2_0,
    input  logic                req_1,
    input  logic [L_word-1:0]   word1_1,
    input  logic [L_word-1:0]   word2_1,
    output logic                grant_0,
    output logic                grant_1,
    output logic                done_0,
    output logic                done_1,
    output logic [2*L_word-1:0] product_0,
    output logic [2*L_word-1:0] product_1,
    output logic                busy
);

    state_e              state_r, state_nxt_s;
    logic [L_cnt-1:0]    cnt_r, cnt_nxt_s;
    logic                add_done_r, add_done_nxt_s;
    logic                owner_r, owner_nxt_s;
    logic                rr_ptr_r, rr_ptr_nxt_s;
    logic                grant_0_r, grant_0_nxt_s;
    logic                grant_1_r, grant_1_nxt_s;
    logic                done_0_r, done_0_nxt_s;
    logic                done_1_r, done_1_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic [2*L_word-1:0] product_0_r, product_0_nxt_s;
    logic [2*L_word-1:0] product_1_r, product_1_nxt_s;

    logic                winner_s;
    logic                load_s, add_s, shift_s;
    logic                m0_s;
    logic [2*L_word-1:0] acc_s;
    logic [L_word-1:0]   word1_sel_s, word2_sel_s;

    // rr_ptr_r names the port that wins a tie; it points away from the last owner.
    always_comb begin
        if (req_0 && req_1) begin
            winner_s = rr_ptr_r;
        end else if (req_1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign word1_sel_s = winner_s ? word1_1 : word1_0;
    assign word2_sel_s = winner_s ? word2_1 : word2_0;

    // Next-state, datapath control and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        add_done_nxt_s  = add_done_r;
        owner_nxt_s     = owner_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        grant_0_nxt_s   = 1'b0;
        grant_1_nxt_s   = 1'b0;
        done_0_nxt_s    = 1'b0;
        done_1_nxt_s    = 1'b0;
        busy_nxt_s      = busy_r;
        product_0_nxt_s = product_0_r;
        product_1_nxt_s = product_1_r;
        load_s          = 1'b0;
        add_s           = 1'b0;
        shift_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_0 || req_1) begin
                    load_s         = 1'b1;
                    cnt_nxt_s      = {L_cnt{1'b0}};
                    add_done_nxt_s = 1'b0;
                    owner_nxt_s    = winner_s;
                    grant_0_nxt_s  = ~winner_s;
                    grant_1_nxt_s  = winner_s;
                    busy_nxt_s     = 1'b1;
                    state_nxt_s    = S_EXEC;
                end else begin
                    state_nxt_s    = S_IDLE;
                end
            end
            S_EXEC: begin
                if (m0_s && !add_done_r) begin
                    add_s          = 1'b1;
                    add_done_nxt_s = 1'b1;
                end else begin
                    shift_s        = 1'b1;
                    add_done_nxt_s = 1'b0;
                    cnt_nxt_s      = cnt_r + L_cnt'(1'b1);
                    // acc already holds the full product once the top bit has been handled
                    if (cnt_r == L_cnt'(L_word - 1)) begin
                        state_nxt_s = S_DONE;
                        if (owner_r) begin
                            product_1_nxt_s = acc_s;
                            done_1_nxt_s    = 1'b1;
                        end else begin
                            product_0_nxt_s = acc_s;
                            done_0_nxt_s    = 1'b1;
                        end
                    end else begin
                        state_nxt_s = S_EXEC;
                    end
                end
            end
            S_DONE: begin
                busy_nxt_s   = 1'b0;
                rr_ptr_nxt_s = ~owner_r;
                state_nxt_s  = S_IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {L_cnt{1'b0}};
            add_done_r  <= 1'b0;
            owner_r     <= 1'b0;
            rr_ptr_r    <= 1'b0;
            grant_0_r   <= 1'b0;
            grant_1_r   <= 1'b0;
            done_0_r    <= 1'b0;
            done_1_r    <= 1'b0;
            busy_r      <= 1'b0;
            product_0_r <= {(2*L_word){1'b0}};
            product_1_r <= {(2*L_word){1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            add_done_r  <= add_done_nxt_s;
            owner_r     <= owner_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            grant_0_r   <= grant_0_nxt_s;
            grant_1_r   <= grant_1_nxt_s;
            done_0_r    <= done_0_nxt_s;
            done_1_r    <= done_1_nxt_s;
            busy_r      <= busy_nxt_s;
            product_0_r <= product_0_nxt_s;
            product_1_r <= product_1_nxt_s;
        end
    end

    shift_add_datapath #(
        .L_word (L_word)
    ) u_datapath (
        .clock  (clock),
        .reset  (reset),
        .load   (load_s),
        .add    (add_s),
        .shift  (shift_s),
        .word1  (word1_sel_s),
        .word2  (word2_sel_s),
        .m0     (m0_s),
        .acc    (acc_s)
    );

    assign grant_0   = grant_0_r;
    assign grant_1   = grant_1_r;
    assign done_0    = done_0_r;
    assign done_1    = done_1_r;
    assign busy      = busy_r;
    assign product_0 = product_0_r;
    assign product_1 = product_1_r;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed plus randomized bench for multiplier_arbiter; expectations come from
// plain arithmetic (a*b, L_word+popcount(b)) and a last-owner round-robin model.
module tb_multiplier_arbiter;

    localparam int L = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           req_0 = 1'b0;
    logic           req_1 = 1'b0;
    logic [L-1:0]   word1_0 = '0, word2_0 = '0, word1_1 = '0, word2_1 = '0;
    logic           grant_0, grant_1, done_0, done_1, busy;
    logic [2*L-1:0] product_0, product_1;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int last_owner = 1;

    multiplier_arbiter #(.L_word(L), .L_cnt(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_0     (req_0),
        .word1_0   (word1_0),
        .word2_0   (word2_0),
        .req_1     (req_1),
        .word1_1   (word1_1),
        .word2_1   (word2_1),
        .grant_0   (grant_0),
        .grant_1   (grant_1),
        .done_0    (done_0),
        .done_1    (done_1),
        .product_0 (product_0),
        .product_1 (product_1),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done_0) done0_cnt <= done0_cnt + 1;
        if (done_1) done1_cnt <= done1_cnt + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return grant_0;
            1:       return grant_1;
            2:       return done_0;
            3:       return done_1;
            4:       return grant_0 | grant_1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic longint prod(input int port);
        return (port == 0) ? longint'(product_0) : longint'(product_1);
    endfunction

    task automatic wait_sig(input int which, input int bound, output int when);
        when = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sig(which)) begin
                when = edge_n;
                break;
            end
        end
    endtask

    task automatic drive(input int port, input logic [L-1:0] a, input logic [L-1:0] b, input logic r);
        if (port == 0) begin
            word1_0 = a; word2_0 = b; req_0 = r;
        end else begin
            word1_1 = a; word2_1 = b; req_1 = r;
        end
    endtask

    task automatic drop(input int port);
        if (port == 0) req_0 = 1'b0;
        else           req_1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        last_owner = 1;
        tick();
    endtask

    task automatic do_op(input int port, input logic [L-1:0] a, input logic [L-1:0] b);
        int tg, td, other_done_prev;
        longint other_prev;
        other_prev      = prod(1 - port);
        other_done_prev = (port == 0) ? done1_cnt : done0_cnt;
        drive(port, a, b, 1'b1);
        wait_sig(port, 20, tg);
        chk("grant_seen", longint'(tg >= 0), 1);
        drop(port);
        wait_sig(2 + port, 40, td);
        chk("latency", td - tg, L + $countones(b));
        chk("product", prod(port), longint'(a) * longint'(b));
        chk("busy_at_done", busy, 1);
        tick();
        chk("done_pulse_end", sig(2 + port), 0);
        chk("busy_end", busy, 0);
        chk("other_product", prod(1 - port), other_prev);
        chk("other_done", (port == 0) ? done1_cnt : done0_cnt, other_done_prev);
        last_owner = port;
    endtask

    task automatic tie_op(input logic [L-1:0] a0, input logic [L-1:0] b0,
                          input logic [L-1:0] a1, input logic [L-1:0] b1);
        int f, s, tg1, td1, tg2, td2;
        logic [L-1:0] aa[2], bb[2];
        aa[0] = a0; bb[0] = b0; aa[1] = a1; bb[1] = b1;
        f = 1 - last_owner;
        s = last_owner;
        drive(0, a0, b0, 1'b1);
        drive(1, a1, b1, 1'b1);
        wait_sig(4, 20, tg1);
        chk("tie_first_grant", sig(f), 1);
        chk("tie_other_grant", sig(s), 0);
        drop(f);
        wait_sig(2 + f, 40, td1);
        chk("tie_first_latency", td1 - tg1, L + $countones(bb[f]));
        chk("tie_first_product", prod(f), longint'(aa[f]) * longint'(bb[f]));
        wait_sig(s, 20, tg2);
        chk("tie_grant_spacing", tg2 - td1, 2);
        drop(s);
        wait_sig(2 + s, 40, td2);
        chk("tie_second_latency", td2 - tg2, L + $countones(bb[s]));
        chk("tie_second_product", prod(s), longint'(aa[s]) * longint'(bb[s]));
        tick();
        last_owner = s;
    endtask

    initial begin
        int tg, td, d0_prev;

        // reset state
        tick();
        tick();
        chk("rst_grant_0", grant_0, 0);
        chk("rst_grant_1", grant_1, 0);
        chk("rst_done_0", done_0, 0);
        chk("rst_done_1", done_1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product_0", product_0, 0);
        chk("rst_product_1", product_1, 0);
        reset = 1'b1;
        tick();

        // single request, 13 x 11
        do_op(0, 4'd13, 4'd11);
        chk("p1_untouched", product_1, 0);
        chk("p1_no_done", done1_cnt, 0);

        // simultaneous requests after reset: port 0 first
        do_reset();
        tie_op(4'd5, 4'd3, 4'd15, 4'd15);

        // both held for four operations: strict alternation
        do_reset();
        drive(0, 4'd2, 4'd1, 1'b1);
        drive(1, 4'd2, 4'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_sig(4, 30, tg);
            chk("alt_grant_0", grant_0, longint'(k % 2 == 0));
            chk("alt_grant_1", grant_1, longint'(k % 2 == 1));
            if (k == 3) begin
                req_0 = 1'b0;
                req_1 = 1'b0;
            end
            wait_sig(2 + (k % 2), 30, td);
            chk("alt_latency", td - tg, 5);
            chk("alt_product", prod(k % 2), 2);
        end
        last_owner = 1;
        repeat (3) tick();
        chk("alt_idle_busy", busy, 0);

        // zero operands
        do_op(1, 4'd0, 4'd15);
        do_op(1, 4'd15, 4'd0);

        // reset in the middle of a 9 x 7 operation with req_0 still held
        drive(0, 4'd9, 4'd7, 1'b1);
        wait_sig(0, 20, tg);
        chk("mid_grant", longint'(tg >= 0), 1);
        repeat (3) tick();
        d0_prev = done0_cnt;
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_grant_0", grant_0, 0);
        chk("mid_done_0", done_0, 0);
        chk("mid_product_0", product_0, 0);
        chk("mid_product_1", product_1, 0);
        repeat (3) tick();
        reset = 1'b1;
        last_owner = 1;
        wait_sig(0, 20, tg);
        chk("mid_regrant", longint'(tg >= 0), 1);
        chk("mid_no_done", done0_cnt, d0_prev);
        req_0 = 1'b0;
        wait_sig(2, 40, td);
        chk("mid_latency", td - tg, 7);
        chk("mid_product", product_0, 63);
        tick();
        last_owner = 0;

        // exhaustive sweep, alternating ports
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op((a * 16 + b) % 2, 4'(a), 4'(b));
            end
        end

        // randomized mix of single and tied requests
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                tie_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                do_op(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
